therm_accum: RTL and testbench

- Downstream consumer of the sorter-network stage.
- Accepts one sorted W-bit thermometer word per beat over a valid/ready handshake and converts it to a binary count of ones.
- Accumulates the counts over a frame delimited by in_last, then presents the frame total on a held output handshake.
- Turns per-word sorter outputs into a per-frame population count.

---
 rtl/bincnt_pkg.sv | 17 +
 rtl/therm2bin.sv | 30 +++
 rtl/therm_accum.sv | 111 +++++++++++
 tb/tb_therm_accum.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bincnt_pkg.sv
// Shared types and sizing helpers for the thermometer-to-count accumulator.
package bincnt_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_W     = 4;
    localparam int DEFAULT_ACC_W = 16;

    // Bits needed to hold a popcount of 0..w.
    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/therm2bin.sv
// Combinational popcount of a sorted thermometer word. The bubble flag port
// exists only when THERM_BUBBLE_CHECK_EN is defined.
module therm2bin
    import bincnt_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0]             i_therm,
`ifdef THERM_BUBBLE_CHECK_EN
    output logic                     o_bubble,
`endif
    output logic [cntWidth(W)-1:0]   o_count
);

    localparam int CW = cntWidth(W);

    // Popcount rather than a priority encoder, so bubbled words still count every 1.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_therm[i]);
        end
    end

`ifdef THERM_BUBBLE_CHECK_EN
    // A 1 with a 0 directly above it breaks the MSB-packed thermometer shape.
    assign o_bubble = |(i_therm[W-2:0] & ~i_therm[W-1:1]);
`endif

endmodule

// File: rtl/therm_accum.sv
// Per-frame saturating population count of sorted thermometer words.
// Optional bubble detection on out_err is enabled by THERM_BUBBLE_CHECK_EN.
module therm_accum
    import bincnt_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_therm,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int CW = cntWidth(W);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] r_outCount;
    logic             r_outOvf;

    logic [CW-1:0]    w_cnt;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_satSum;
    logic             w_sumOvf;
    logic             w_accept;

`ifdef THERM_BUBBLE_CHECK_EN
    logic             w_bubble;
    logic             r_err;
    logic             r_outErr;
`endif

    therm2bin #(.W(W)) u_conv (
        .i_therm  (in_therm),
`ifdef THERM_BUBBLE_CHECK_EN
        .o_bubble (w_bubble),
`endif
        .o_count  (w_cnt)
    );

    // One extra bit on the sum exposes the carry that triggers saturation.
    assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(w_cnt);
    assign w_sumOvf = w_sum[ACC_W];
    assign w_satSum = w_sumOvf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_accept = in_valid & in_ready;

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_count = r_outCount;
    assign out_ovf   = r_outOvf;
`ifdef THERM_BUBBLE_CHECK_EN
    assign out_err   = r_outErr;
`else
    assign out_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
`ifdef THERM_BUBBLE_CHECK_EN
            r_err      <= 1'b0;
            r_outErr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_outCount <= w_satSum;
                            r_outOvf   <= r_ovf | w_sumOvf;
                            r_acc      <= '0;
                            r_ovf      <= 1'b0;
`ifdef THERM_BUBBLE_CHECK_EN
                            r_outErr   <= r_err | w_bubble;
                            r_err      <= 1'b0;
`endif
                            r_state    <= HOLD;
                        end else begin
                            r_acc      <= w_satSum;
                            r_ovf      <= r_ovf | w_sumOvf;
`ifdef THERM_BUBBLE_CHECK_EN
                            r_err      <= r_err | w_bubble;
`endif
                        end
                    end
                end
                HOLD: begin
                    // Input stays blocked even on the release cycle: one bubble per frame.
                    if (out_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_therm_accum.sv
// Self-checking bench for therm_accum: directed scenarios plus random frames,
// checked against a frame-level arithmetic model on ACC_W=16 and ACC_W=4 instances.
module tb_therm_accum;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_therm;
    logic          in_last;
    logic          out_ready;

    logic          inReady16, outValid16, outOvf16, outErr16;
    logic [15:0]   outCount16;
    logic          inReady4, outValid4, outOvf4, outErr4;
    logic [3:0]    outCount4;

    int compared   = 0;
    int mismatched = 0;

    int frameSum;
    bit frameErr;
    int expCount16, expCount4;
    bit expOvf16, expOvf4, expErr;

    always #5 clk = ~clk;

    therm_accum #(.W(W), .ACC_W(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (inReady16),
        .in_therm  (in_therm),
        .in_last   (in_last),
        .out_valid (outValid16),
        .out_ready (out_ready),
        .out_count (outCount16),
        .out_ovf   (outOvf16),
        .out_err   (outErr16)
    );

    therm_accum #(.W(W), .ACC_W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (inReady4),
        .in_therm  (in_therm),
        .in_last   (in_last),
        .out_valid (outValid4),
        .out_ready (out_ready),
        .out_count (outCount4),
        .out_ovf   (outOvf4),
        .out_err   (outErr4)
    );

    // A legal word is k ones packed against the MSB, for some k in 0..W.
    function automatic bit isTherm(input logic [W-1:0] word);
        for (int k = 0; k <= W; k++) begin
            if (int'(word) == (((1 << W) - 1) ^ ((1 << (W - k)) - 1))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clearFrame();
        frameSum = 0;
        frameErr = 1'b0;
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_valid16"}, 32'(outValid16), 32'd1);
        checkOutput({tag, "_valid4"},  32'(outValid4),  32'd1);
        checkOutput({tag, "_count16"}, 32'(outCount16), 32'(expCount16));
        checkOutput({tag, "_count4"},  32'(outCount4),  32'(expCount4));
        checkOutput({tag, "_ovf16"},   32'(outOvf16),   32'(expOvf16));
        checkOutput({tag, "_ovf4"},    32'(outOvf4),    32'(expOvf4));
        checkOutput({tag, "_err16"},   32'(outErr16),   32'(expErr));
        checkOutput({tag, "_err4"},    32'(outErr4),    32'(expErr));
        checkOutput({tag, "_ready"},   32'(inReady16),  32'd0);
    endtask

    // Drives one beat, waits for acceptance, and updates the frame model.
    task automatic applyStimulus(input logic [W-1:0] word, input bit last, input string tag);
        int n = 0;
        in_valid = 1'b1;
        in_therm = word;
        in_last  = last;
        while (inReady16 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_accept"}, 32'(inReady16), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_therm = W'($urandom);
        in_last  = 1'($urandom);
        frameSum += $countones(word);
        if (!isTherm(word)) frameErr = 1'b1;
        if (last) begin
            expCount16 = (frameSum > 65535) ? 65535 : frameSum;
            expOvf16   = (frameSum > 65535);
            expCount4  = (frameSum > 15) ? 15 : frameSum;
            expOvf4    = (frameSum > 15);
`ifdef THERM_BUBBLE_CHECK_EN
            expErr     = frameErr;
`else
            expErr     = 1'b0;
`endif
            clearFrame();
            checkResult(tag);
        end
    endtask

    // Holds the result for some cycles (optionally with a stalled beat), then releases it.
    task automatic releaseResult(input int holdCycles, input bit pendValid, input string tag);
        if (pendValid) begin
            in_valid = 1'b1;
            in_therm = 4'b1100;
            in_last  = 1'b0;
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_holdValid"}, 32'(outValid16), 32'd1);
            checkOutput({tag, "_holdReady"}, 32'(inReady16),  32'd0);
            checkOutput({tag, "_holdCount"}, 32'(outCount16), 32'(expCount16));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput({tag, "_relValid"}, 32'(outValid16), 32'd0);
        checkOutput({tag, "_relReady"}, 32'(inReady16),  32'd1);
    endtask

    // Asserts reset away from any clock edge and checks the immediate clear.
    task automatic doReset(input string tag);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_valid16"}, 32'(outValid16), 32'd0);
        checkOutput({tag, "_valid4"},  32'(outValid4),  32'd0);
        checkOutput({tag, "_count16"}, 32'(outCount16), 32'd0);
        checkOutput({tag, "_ovf4"},    32'(outOvf4),    32'd0);
        checkOutput({tag, "_err16"},   32'(outErr16),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clearFrame();
        #1;
        checkOutput({tag, "_ready"}, 32'(inReady16), 32'd1);
    endtask

    initial begin
        int len;
        logic [W-1:0] word;
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_therm  = '0;
        in_last   = 1'b0;
        clearFrame();

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_therm  = W'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
        end
        checkOutput("rst_valid", 32'(outValid16), 32'd0);
        checkOutput("rst_count", 32'(outCount16), 32'd0);
        checkOutput("rst_ovf",   32'(outOvf16),   32'd0);
        checkOutput("rst_err",   32'(outErr16),   32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(inReady16), 32'd1);

        applyStimulus(4'b1000, 1'b0, "f1");
        applyStimulus(4'b1100, 1'b0, "f1");
        applyStimulus(4'b1111, 1'b1, "f1");
        releaseResult(0, 1'b0, "f1");

        applyStimulus(4'b1110, 1'b0, "bp");
        applyStimulus(4'b1111, 1'b1, "bp");
        releaseResult(5, 1'b1, "bp");
        applyStimulus(4'b1100, 1'b0, "bp2");
        applyStimulus(4'b1000, 1'b1, "bp2");
        releaseResult(1, 1'b0, "bp2");

        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, (i == 4), "sat");
        releaseResult(0, 1'b0, "sat");
        applyStimulus(4'b1000, 1'b1, "satNext");
        releaseResult(0, 1'b0, "satNext");

        applyStimulus(4'b1111, 1'b0, "rmf");
        applyStimulus(4'b1111, 1'b0, "rmf");
        doReset("rmfRst");
        applyStimulus(4'b1100, 1'b1, "rmf");
        releaseResult(0, 1'b0, "rmf");

        applyStimulus(4'b0101, 1'b0, "bub");
        applyStimulus(4'b1110, 1'b1, "bub");
        releaseResult(0, 1'b0, "bub");
        applyStimulus(4'b1000, 1'b1, "bubNext");
        releaseResult(0, 1'b0, "bubNext");

        applyStimulus(4'b1111, 1'b1, "rhold");
        doReset("rholdRst");

        applyStimulus(4'b0000, 1'b0, "zero");
        applyStimulus(4'b0000, 1'b1, "zero");
        releaseResult(0, 1'b0, "zero");

        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 1) == 0) begin
                    word = W'(((1 << W) - 1) ^ ((1 << (W - $urandom_range(0, W))) - 1));
                end else begin
                    word = W'($urandom);
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                applyStimulus(word, (b == len - 1), "rnd");
            end
            releaseResult($urandom_range(0, 3), 1'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
